spi_mpu_burst: RTL

//  SPI master for MPU9250-class sensors (mode 3: sclk idle high, MOSI changes on falling edge, MISO sampled on rising edge).

---
 rtl/spi_mpu_burst.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spi_mpu_burst.sv
// SPI mode-3 master for MPU9250-class sensors. One chip-select frame carries a
// command byte {rw, addr} followed by len+1 data bytes. Read bytes stream out
// with rd_valid; write bytes are pulled from a first-word-fall-through FIFO
// with wr_pop. Each frame ends with a cs_n-high idle gap before finish.
module spi_mpu_burst #(
  parameter  int CLK_DIV   = 2,
  parameter  int HOLD_BITS = 8,
  parameter  int MAX_BYTES = 16,
  localparam int LEN_BITS  = $clog2(MAX_BYTES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                rw,
  input  logic [6:0]          addr,
  input  logic [LEN_BITS-1:0] len,
  input  logic [7:0]          wr_data,
  input  logic                miso,
  output logic                wr_pop,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                sclk,
  output logic                mosi,
  output logic                cs_n,
  output logic                busy,
  output logic                finish
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TAIL, HOLD} state_t;

  // Last phase value of the low half of an sclk period (P/2 - 1).
  localparam logic [CLK_DIV-1:0] HALF_LAST = {1'b0, {(CLK_DIV-1){1'b1}}};

  state_t              state, state_next;
  logic [CLK_DIV-1:0]  phase;      // position inside one sclk period, also SETUP/TAIL timer
  logic [HOLD_BITS-1:0] hold_cnt;
  logic [2:0]          bit_cnt;
  logic [LEN_BITS:0]   byte_cnt;   // 0 = command byte; one extra bit so len=MAX-1 never wraps
  logic [LEN_BITS:0]   last_byte;  // index of the final data byte, latched at start
  logic                rw_q;
  logic [7:0]          shifter;
  logic [6:0]          rx;         // first seven samples of the byte in flight

  logic phase_end, half_end, sample, byte_end, frame_end;

  assign phase_end = (phase == '1);
  assign half_end  = (phase == HALF_LAST);
  assign sample    = (state == SHIFT) && half_end;  // this edge raises sclk
  assign byte_end  = (state == SHIFT) && phase_end && (bit_cnt == 3'd7);
  assign frame_end = byte_end && (byte_cnt == last_byte);

  // Pins derive from registered state only, so reset forces them at once.
  assign sclk   = (state != SHIFT) || phase[CLK_DIV-1];
  assign cs_n   = (state == IDLE) || (state == HOLD);
  assign mosi   = (state == SHIFT) && shifter[7];
  assign busy   = (state != IDLE);
  assign wr_pop = byte_end && !frame_end && !rw_q;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start)           state_next = SETUP;
      SETUP: if (half_end)        state_next = SHIFT;
      SHIFT: if (frame_end)       state_next = TAIL;
      TAIL:  if (half_end)        state_next = HOLD;
      HOLD:  if (hold_cnt == '1)  state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Phase and hold timers; phase restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      hold_cnt <= '0;
    end else begin
      if (state == IDLE || state_next != state) phase <= '0;
      else                                      phase <= phase + 1'b1;
      hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
    end
  end

  // Frame datapath: latch command at start, shift MSB first, reload at byte ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q      <= 1'b0;
      last_byte <= '0;
      shifter   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      rx        <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        rw_q      <= rw;
        last_byte <= {1'b0, len} + 1'b1;
        shifter   <= {rw, addr};
        bit_cnt   <= '0;
        byte_cnt  <= '0;
      end
    end else if (state == SHIFT) begin
      if (sample) rx <= {rx[5:0], miso};
      if (phase_end) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) begin
          byte_cnt <= byte_cnt + 1'b1;
          // Read data bytes and the post-frame idle drive mosi low.
          shifter  <= wr_pop ? wr_data : 8'h00;
        end else begin
          shifter  <= {shifter[6:0], 1'b0};
        end
      end
    end
  end

  // Read byte delivery and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      finish   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (sample && bit_cnt == 3'd7 && byte_cnt != '0 && rw_q) begin
        rd_data  <= {rx, miso};
        rd_valid <= 1'b1;
      end
      finish <= (state == HOLD) && (hold_cnt == '1);
    end
  end

endmodule
